// File: rtl/user_mgmt_slave_mc_if.sv
// Bus bundle between the localbus master, the management slave and its NUM_CH config targets.
// The slave modport is the bridge; the master modport drives localbus requests and config replies.
interface user_mgmt_slave_mc_if #(
    parameter int NUM_CH    = 4,
    parameter int CH_ADDR_W = 16
);
    logic                   localbus_cs_n;
    logic                   localbus_rd_wr;
    logic [31:0]            localbus_data;
    logic                   localbus_ale;
    logic                   localbus_ack_n;
    logic [31:0]            localbus_data_out;
    logic [NUM_CH-1:0]      cfg_cs;
    logic                   cfg_rw;
    logic [CH_ADDR_W-1:0]   cfg_addr;
    logic [31:0]            cfg_wdata;
    logic [NUM_CH-1:0]      cfg_ack;
    logic [NUM_CH*32-1:0]   cfg_rdata;
    logic [15:0]            unmapped_cnt;
    logic [15:0]            timeout_cnt;

    modport slave (
        input  localbus_cs_n, localbus_rd_wr, localbus_data, localbus_ale,
        output localbus_ack_n, localbus_data_out,
        output cfg_cs, cfg_rw, cfg_addr, cfg_wdata,
        input  cfg_ack, cfg_rdata,
        output unmapped_cnt, timeout_cnt
    );

    modport master (
        output localbus_cs_n, localbus_rd_wr, localbus_data, localbus_ale,
        input  localbus_ack_n, localbus_data_out,
        input  cfg_cs, cfg_rw, cfg_addr, cfg_wdata,
        output cfg_ack, cfg_rdata,
        input  unmapped_cnt, timeout_cnt
    );
endinterface

// File: rtl/user_mgmt_slave_mc.sv
// Multi-channel localbus management slave: decodes a channel from the latched address and runs one
// cs/ack handshake on it, with unmapped-address and timeout responses plus saturating error counters.
module user_mgmt_slave_mc #(
    parameter int          NUM_CH    = 4,
    parameter int          SEL_HI    = 31,
    parameter int          SEL_LO    = 20,
    parameter int          CH_ADDR_W = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF,
    parameter logic [31:0] TO_DATA   = 32'hFFFF_FFFF
) (
    input logic clk,
    input logic rst,
    user_mgmt_slave_mc_if.slave bus
);
    localparam int SEL_W = SEL_HI - SEL_LO + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_CS, REQ, RESP} state_t;

    state_t                 state;
    logic [CH_W-1:0]        ch;
    logic                   mapped;
    logic [CH_ADDR_W-1:0]   addr_lat;
    logic [15:0]            timer;

    logic [SEL_W-1:0]       sel;
    logic                   sel_mapped;
    logic [NUM_CH-1:0]      ch_onehot;
    logic                   ch_ack;
    logic [31:0]            ch_rdata;

    // Only the latched channel's ack and read data are ever looked at.
    assign sel        = bus.localbus_data[SEL_HI:SEL_LO];
    assign sel_mapped = ({{(32-SEL_W){1'b0}}, sel} < 32'(NUM_CH));
    assign ch_ack     = bus.cfg_ack[ch];
    assign ch_rdata   = bus.cfg_rdata[32*ch +: 32];

    always_comb begin
        ch_onehot     = '0;
        ch_onehot[ch] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            ch                    <= '0;
            mapped                <= 1'b0;
            addr_lat              <= '0;
            timer                 <= '0;
            bus.cfg_cs            <= '0;
            bus.cfg_rw            <= 1'b0;
            bus.cfg_addr          <= '0;
            bus.cfg_wdata         <= '0;
            bus.localbus_ack_n    <= 1'b1;
            bus.localbus_data_out <= '0;
            bus.unmapped_cnt      <= '0;
            bus.timeout_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.localbus_ale) begin
                        addr_lat <= bus.localbus_data[CH_ADDR_W-1:0];
                        ch       <= sel[CH_W-1:0];
                        mapped   <= sel_mapped;
                        state    <= WAIT_CS;
                    end
                end
                WAIT_CS: begin
                    if (bus.localbus_ale) begin
                        addr_lat <= bus.localbus_data[CH_ADDR_W-1:0];
                        ch       <= sel[CH_W-1:0];
                        mapped   <= sel_mapped;
                    end else if (!bus.localbus_cs_n) begin
                        if (mapped) begin
                            bus.cfg_cs    <= ch_onehot;
                            bus.cfg_rw    <= ~bus.localbus_rd_wr;
                            bus.cfg_addr  <= addr_lat;
                            bus.cfg_wdata <= bus.localbus_data;
                            timer         <= '0;
                            state         <= REQ;
                        end else begin
                            // Unmapped channels complete at once without touching any target.
                            bus.localbus_data_out <= ERR_DATA;
                            bus.localbus_ack_n    <= 1'b0;
                            if (bus.unmapped_cnt != 16'hFFFF)
                                bus.unmapped_cnt <= bus.unmapped_cnt + 16'd1;
                            state <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (bus.localbus_cs_n) begin
                        bus.cfg_cs <= '0;
                        state      <= IDLE;
                    end else if (ch_ack) begin
                        bus.cfg_cs            <= '0;
                        bus.localbus_data_out <= ch_rdata;
                        bus.localbus_ack_n    <= 1'b0;
                        state                 <= RESP;
                    end else if (timer == 16'(TIMEOUT - 1)) begin
                        bus.cfg_cs            <= '0;
                        bus.localbus_data_out <= TO_DATA;
                        bus.localbus_ack_n    <= 1'b0;
                        if (bus.timeout_cnt != 16'hFFFF)
                            bus.timeout_cnt <= bus.timeout_cnt + 16'd1;
                        state <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    if (bus.localbus_cs_n) begin
                        bus.localbus_ack_n <= 1'b1;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
